// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO input conditioning path.
package gpio_pkg;

  typedef enum logic {
    GPIO_INT_EDGE,
    GPIO_INT_LEVEL
  } gpio_int_mode_e;

  localparam int unsigned GPIO_SYNC_MIN      = 2;
  localparam int unsigned GPIO_CNT_W_DEFAULT = 8;

endpackage

// File: rtl/gpio_in_bit.sv
// One GPIO input bit: synchroniser, optional glitch filter, edge detect, sticky status.
// The glitch filter counter exists only when GPIO_INPUT_FILTER_EN is defined.
module gpio_in_bit
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = GPIO_CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             raw_i,
  input  logic             filt_en_i,
  input  logic [CNT_W-1:0] filt_thresh_i,
  input  logic             int_level_i,
  input  logic             int_pol_i,
  input  logic             int_both_i,
  input  logic             int_clr_i,
  input  logic             evt_mask_i,
  output logic             data_o,
  output logic             status_o
);

  if (SYNC_STAGES < GPIO_SYNC_MIN) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_bit;
  logic                   stable_q, stable_d;
  logic                   prev_q;
  logic                   status_q, status_d;
  logic                   rise, fall, evt;
  gpio_int_mode_e         mode;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};

`ifdef GPIO_INPUT_FILTER_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt never exceeds thresh, so it cannot wrap; >= covers a lowered thresh
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (!filt_en_i) begin
      stable_d = sync_bit;
    end else if (sync_bit != stable_q) begin
      if (cnt_q >= filt_thresh_i) stable_d = sync_bit;
      else                        cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_filt;
  assign unused_filt = filt_en_i ^ (^filt_thresh_i);

  always_comb stable_d = sync_bit;
`endif

  always_comb begin
    mode = int_level_i ? GPIO_INT_LEVEL : GPIO_INT_EDGE;
    rise = stable_q & ~prev_q;
    fall = ~stable_q & prev_q;
    evt  = 1'b0;
    unique case (mode)
      GPIO_INT_LEVEL: evt = int_pol_i ? stable_q : ~stable_q;
      GPIO_INT_EDGE:  evt = int_both_i ? (rise | fall) : (int_pol_i ? rise : fall);
    endcase
    if (evt_mask_i) evt = 1'b0;
    // Edge events beat a simultaneous clear; a level clear drops status for one cycle
    status_d = (evt & ~(int_level_i & int_clr_i)) | (status_q & ~int_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      status_q <= status_d;
    end
  end

  assign data_o   = stable_q;
  assign status_o = status_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-bit conditioning, shared post-reset warm-up mask, irq reduction.
// Optional glitch filter selected by GPIO_INPUT_FILTER_EN.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_BITS    = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = GPIO_CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BITS-1:0] i_raw,
  input  logic [NUM_BITS-1:0] filt_en,
  input  logic [CNT_W-1:0]    filt_thresh,
  input  logic [NUM_BITS-1:0] int_en,
  input  logic [NUM_BITS-1:0] int_level,
  input  logic [NUM_BITS-1:0] int_pol,
  input  logic [NUM_BITS-1:0] int_both,
  input  logic [NUM_BITS-1:0] int_clr,
  output logic [NUM_BITS-1:0] data_in,
  output logic [NUM_BITS-1:0] int_status,
  output logic                irq
);

  // Masking runs through the cycle in which a pin held high at reset first
  // shows its rise at the edge detector.
  localparam int unsigned WARM_END = SYNC_STAGES + 2;
  localparam int unsigned WARM_W   = $clog2(WARM_END + 1);

  logic [WARM_W-1:0] warm_q, warm_d;
  logic              evt_mask;

  assign evt_mask = (warm_q != WARM_W'(WARM_END));

  always_comb begin
    warm_d = warm_q;
    if (evt_mask) warm_d = warm_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) warm_q <= '0;
    else          warm_q <= warm_d;
  end

  for (genvar b = 0; b < NUM_BITS; b++) begin : g_bit
    gpio_in_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_bit (
      .clk_i        (clk),
      .rst_ni       (reset_n),
      .raw_i        (i_raw[b]),
      .filt_en_i    (filt_en[b]),
      .filt_thresh_i(filt_thresh),
      .int_level_i  (int_level[b]),
      .int_pol_i    (int_pol[b]),
      .int_both_i   (int_both[b]),
      .int_clr_i    (int_clr[b]),
      .evt_mask_i   (evt_mask),
      .data_o       (data_in[b]),
      .status_o     (int_status[b])
    );
  end

  assign irq = |(int_status & int_en);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed self-checking bench for gpio_input_conditioner (SYNC_STAGES=2).
// Filter-specific expectations follow GPIO_INPUT_FILTER_EN.
module tb_gpio_input_conditioner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] i_raw, filt_en, int_en, int_level, int_pol, int_both, int_clr;
  logic [7:0]  filt_thresh;
  logic [31:0] data_in, int_status;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpio_input_conditioner #(
    .NUM_BITS   (32),
    .SYNC_STAGES(2),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_raw      (i_raw),
    .filt_en    (filt_en),
    .filt_thresh(filt_thresh),
    .int_en     (int_en),
    .int_level  (int_level),
    .int_pol    (int_pol),
    .int_both   (int_both),
    .int_clr    (int_clr),
    .data_in    (data_in),
    .int_status (int_status),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse(input logic [31:0] m);
    int_clr = m;
    step(1);
    int_clr = '0;
  endtask

  initial begin
    reset_n     = 1'b0;
    i_raw       = '1;
    filt_en     = '0;
    filt_thresh = '0;
    int_en      = '1;
    int_level   = '0;
    int_pol     = '1;
    int_both    = '0;
    int_clr     = '0;
    step(3);
    check("rst_data", data_in, 32'h0);
    check("rst_status", int_status, 32'h0);
    check("rst_irq", irq, 1'b0);

    // pins high through reset release: data after 3 edges, no rising event
    reset_n = 1'b1;
    step(2);
    check("warm_data_lat", data_in, 32'h0);
    step(1);
    check("warm_data", data_in, 32'hFFFF_FFFF);
    step(6);
    check("warm_status", int_status, 32'h0);
    check("warm_irq", irq, 1'b0);

    i_raw = '0;
    step(6);
    check("fall_no_evt", int_status, 32'h0);

    // bit0 rising edge: data at +3, status/irq at +4
    i_raw = 32'h1;
    step(2);
    check("b0_data_early", data_in, 32'h0);
    step(1);
    check("b0_data", data_in, 32'h1);
    check("b0_status_early", int_status, 32'h0);
    step(1);
    check("b0_status", int_status, 32'h1);
    check("b0_irq", irq, 1'b1);
    clr_pulse(32'h1);
    check("b0_clr", int_status, 32'h0);
    check("b0_clr_irq", irq, 1'b0);

    // bit5 both edges, 20-cycle spacing
    int_both = 32'h20;
    i_raw    = 32'h21;
    step(4);
    check("b5_rise", int_status, 32'h20);
    clr_pulse(32'h20);
    check("b5_clr", int_status, 32'h0);
    step(15);
    i_raw = 32'h1;
    step(4);
    check("b5_fall", int_status, 32'h20);
    clr_pulse(32'h20);
    check("b5_clr2", int_status, 32'h0);
    i_raw = 32'h21;
    step(3);
    int_clr = 32'h20;
    step(1);
    int_clr = '0;
    check("b5_set_wins", int_status, 32'h20);
    clr_pulse(32'h20);
    check("b5_clr3", int_status, 32'h0);

    // bit6 falling-only
    int_pol = ~32'h40;
    i_raw   = 32'h61;
    step(6);
    check("b6_rise_ign", int_status, 32'h0);
    i_raw = 32'h21;
    step(4);
    check("b6_fall", int_status, 32'h40);
    clr_pulse(32'h40);

    // bit7 level-low
    int_level = 32'h80;
    int_pol   = ~32'hC0;
    step(1);
    check("b7_lvl", int_status, 32'h80);
    clr_pulse(32'h80);
    check("b7_lvl_clr", int_status, 32'h0);
    step(1);
    check("b7_lvl_reassert", int_status, 32'h80);
    i_raw = 32'hA1;
    step(3);
    check("b7_lvl_sticky", int_status, 32'h80);
    clr_pulse(32'h80);
    check("b7_lvl_clr2", int_status, 32'h0);
    step(3);
    check("b7_lvl_stays", int_status, 32'h0);

    // irq masked by int_en, status unaffected
    i_raw = 32'hA0;
    step(4);
    i_raw = 32'hA1;
    step(4);
    check("b0_reset_status", int_status, 32'h1);
    int_en = ~32'h1;
    step(1);
    check("irq_masked", irq, 1'b0);
    check("status_unmasked", int_status, 32'h1);
    int_en = '1;
    step(1);
    check("irq_unmasked", irq, 1'b1);

    // bit3 filter, thresh=4
    filt_en     = 32'h8;
    filt_thresh = 8'd4;
`ifdef GPIO_INPUT_FILTER_EN
    i_raw = 32'hA9;
    step(4);
    i_raw = 32'hA1;
    step(10);
    check("filt_glitch_data", data_in[3], 1'b0);
    check("filt_glitch_status", int_status[3], 1'b0);
    i_raw = 32'hA9;
    step(5);
    i_raw = 32'hA1;
    step(1);
    check("filt_pass_early", data_in[3], 1'b0);
    step(1);
    check("filt_pass", data_in[3], 1'b1);
    step(1);
    check("filt_pass_status", int_status[3], 1'b1);
    step(12);
`else
    i_raw = 32'hA9;
    step(1);
    i_raw = 32'hA1;
    step(2);
    check("nofilt_pulse", data_in[3], 1'b1);
    step(1);
    check("nofilt_pulse_end", data_in[3], 1'b0);
    step(4);
`endif

    // async reset mid-count, then count restarts from zero
    i_raw = 32'hA9;
    step(5);
    reset_n = 1'b0;
    #2;
    check("rst_async_data", data_in, 32'h0);
    check("rst_async_status", int_status, 32'h0);
    check("rst_async_irq", irq, 1'b0);
    step(1);
    reset_n = 1'b1;
`ifdef GPIO_INPUT_FILTER_EN
    step(6);
    check("filt_restart_early", data_in[3], 1'b0);
    step(1);
    check("filt_restart", data_in[3], 1'b1);
`else
    step(2);
    check("restart_early", data_in[3], 1'b0);
    step(1);
    check("restart", data_in[3], 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
